// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that steers NUM_MASTERS byte-wide requesters onto one RAM port and one I/O port.
// Read data returns one cycle after the grant, routed by registered source/region tags.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int DATA_WIDTH     = 8,
  parameter int IO_SEL_WIDTH   = 3,
  parameter int DBG_MASTER     = NUM_MASTERS - 1
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dout,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [DATA_WIDTH-1:0]             m_din,
  input  logic                              dbg_active,
  output logic                              ram_en,
  output logic                              ram_r_nw,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_a,
  output logic [DATA_WIDTH-1:0]             ram_d_in,
  input  logic [DATA_WIDTH-1:0]             ram_d_out,
  output logic                              io_en,
  output logic [IO_SEL_WIDTH-1:0]           io_sel,
  output logic                              io_wr,
  output logic [DATA_WIDTH-1:0]             io_din,
  input  logic [DATA_WIDTH-1:0]             io_dout,
  input  logic                              io_full
);

  localparam int PTR_W = $clog2(NUM_MASTERS);

  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      rd_pending_q, rd_pending_d;
  logic [PTR_W-1:0]          rd_src_q, rd_src_d;
  logic                      rd_io_q, rd_io_d;

  logic [NUM_MASTERS-1:0]    is_io;
  logic [NUM_MASTERS-1:0]    elig;
  logic [NUM_MASTERS-1:0]    gnt;
  logic                      any_gnt;
  logic [RAM_ADDR_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0]     sel_d;
  logic                      sel_wr;
  logic                      sel_io;
  logic [PTR_W-1:0]          sel_idx;
  logic                      ram_acc;
  logic                      io_acc;

  // Address bits above the region-decode field carry no meaning here.
  logic                      unused_addr_bits;
  assign unused_addr_bits = ^m_a;

  function automatic int wrap_idx(input int v);
    if (v >= NUM_MASTERS) return v - NUM_MASTERS;
    return v;
  endfunction

  always_comb begin
    is_io = '0;
    elig  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      is_io[i] = (m_a[i*ADDR_WIDTH + RAM_ADDR_WIDTH -: 2] == 2'b11);
      elig[i]  = m_req[i]
                 && !(is_io[i] && m_wr[i] && io_full)
                 && !(dbg_active && (i != DBG_MASTER));
    end
  end

  always_comb begin
    gnt = '0;
    if (!rst_in) begin
      for (int off = 0; off < NUM_MASTERS; off++) begin
        if (gnt == '0 && elig[wrap_idx(int'(rr_ptr_q) + off)])
          gnt[wrap_idx(int'(rr_ptr_q) + off)] = 1'b1;
      end
    end
  end

  always_comb begin
    any_gnt = |gnt;
    sel_a   = '0;
    sel_d   = '0;
    sel_wr  = 1'b0;
    sel_io  = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt[i]) begin
        sel_a   = m_a[i*ADDR_WIDTH +: RAM_ADDR_WIDTH];
        sel_d   = m_dout[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wr  = m_wr[i];
        sel_io  = is_io[i];
        sel_idx = PTR_W'(i);
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (any_gnt)
      rr_ptr_d = (sel_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : sel_idx + 1'b1;
    rd_pending_d = any_gnt && !sel_wr;
    rd_src_d     = any_gnt ? sel_idx : rd_src_q;
    rd_io_d      = any_gnt ? sel_io  : rd_io_q;
  end

  // Address/data outputs are zeroed on the port that is not being accessed.
  always_comb begin
    ram_acc  = any_gnt && !sel_io;
    io_acc   = any_gnt && sel_io;

    m_gnt    = gnt;
    ram_en   = ram_acc;
    ram_r_nw = !(ram_acc && sel_wr);
    ram_a    = ram_acc ? sel_a : '0;
    ram_d_in = ram_acc ? sel_d : '0;
    io_en    = io_acc;
    io_wr    = io_acc && sel_wr;
    io_sel   = io_acc ? sel_a[IO_SEL_WIDTH-1:0] : '0;
    io_din   = io_acc ? sel_d : '0;

    m_rvalid = '0;
    m_din    = '0;
    if (rd_pending_q && !rst_in) begin
      m_rvalid[rd_src_q] = 1'b1;
      m_din              = rd_io_q ? io_dout : ram_d_out;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q     <= '0;
      rd_pending_q <= 1'b0;
      rd_src_q     <= '0;
      rd_io_q      <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rd_pending_q <= rd_pending_d;
      rd_src_q     <= rd_src_d;
      rd_io_q      <= rd_io_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a per-cycle vector table with hand-computed expectations,
// followed by a hand-written reset/recovery sequence. Small RAM/IO models answer reads one cycle late.
module tb_mem_bus_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic [2:0]  m_req;
  logic [2:0]  m_wr;
  logic [95:0] m_a;
  logic [23:0] m_dout;
  logic [2:0]  m_gnt;
  logic [2:0]  m_rvalid;
  logic [7:0]  m_din;
  logic        dbg_active;
  logic        ram_en;
  logic        ram_r_nw;
  logic [16:0] ram_a;
  logic [7:0]  ram_d_in;
  logic [7:0]  ram_d_out;
  logic        io_en;
  logic [2:0]  io_sel;
  logic        io_wr;
  logic [7:0]  io_din;
  logic [7:0]  io_dout;
  logic        io_full;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic        dbg;
    logic        full;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [2:0]  e_gnt;
    logic [2:0]  e_rvalid;
    logic [7:0]  e_din;
    logic        e_ram_en;
    logic        e_r_nw;
    logic [16:0] e_ram_a;
    logic [7:0]  e_ram_d;
    logic        e_io_en;
    logic        e_io_wr;
    logic [2:0]  e_io_sel;
    logic [7:0]  e_io_din;
  } vec_t;

  localparam logic [31:0] RA0 = 32'h0000_0100;
  localparam logic [31:0] RA1 = 32'h0000_0200;
  localparam logic [31:0] RA2 = 32'h0000_0300;
  localparam logic [31:0] Z   = 32'h0000_0000;

  vec_t vecs[27];

  mem_bus_arbiter dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_a        (m_a),
    .m_dout     (m_dout),
    .m_gnt      (m_gnt),
    .m_rvalid   (m_rvalid),
    .m_din      (m_din),
    .dbg_active (dbg_active),
    .ram_en     (ram_en),
    .ram_r_nw   (ram_r_nw),
    .ram_a      (ram_a),
    .ram_d_in   (ram_d_in),
    .ram_d_out  (ram_d_out),
    .io_en      (io_en),
    .io_sel     (io_sel),
    .io_wr      (io_wr),
    .io_din     (io_din),
    .io_dout    (io_dout),
    .io_full    (io_full)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // RAM returns a byte derived from its address; I/O returns 0xC0 | select.
  always @(posedge clk_in) begin
    if (ram_en && ram_r_nw) ram_d_out <= ram_a[15:8] ^ ram_a[7:0] ^ 8'h5A;
    if (io_en && !io_wr)    io_dout   <= 8'hC0 | {5'b00000, io_sel};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk_in);
    rst_in     = v.rst;
    dbg_active = v.dbg;
    io_full    = v.full;
    m_req      = v.req;
    m_wr       = v.wr;
    m_a        = {v.a2, v.a1, v.a0};
    m_dout     = {8'h00, v.d1, v.d0};
    #1;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d m_gnt", i),    32'(m_gnt),    32'(v.e_gnt));
    checkOutput($sformatf("v%0d m_rvalid", i), 32'(m_rvalid), 32'(v.e_rvalid));
    checkOutput($sformatf("v%0d m_din", i),    32'(m_din),    32'(v.e_din));
    checkOutput($sformatf("v%0d ram_en", i),   32'(ram_en),   32'(v.e_ram_en));
    checkOutput($sformatf("v%0d ram_r_nw", i), 32'(ram_r_nw), 32'(v.e_r_nw));
    checkOutput($sformatf("v%0d ram_a", i),    32'(ram_a),    32'(v.e_ram_a));
    checkOutput($sformatf("v%0d ram_d_in", i), 32'(ram_d_in), 32'(v.e_ram_d));
    checkOutput($sformatf("v%0d io_en", i),    32'(io_en),    32'(v.e_io_en));
    checkOutput($sformatf("v%0d io_wr", i),    32'(io_wr),    32'(v.e_io_wr));
    checkOutput($sformatf("v%0d io_sel", i),   32'(io_sel),   32'(v.e_io_sel));
    checkOutput($sformatf("v%0d io_din", i),   32'(io_din),   32'(v.e_io_din));
  endtask

  initial begin
    int waited;
    checks     = 0;
    errors     = 0;
    rst_in     = 1'b1;
    dbg_active = 1'b0;
    io_full    = 1'b0;
    m_req      = '0;
    m_wr       = '0;
    m_a        = '0;
    m_dout     = '0;
    ram_d_out  = '0;
    io_dout    = '0;

    // reset held with all masters requesting
    vecs[0]  = '{1'b1,1'b0,1'b0,3'b111,3'b000,RA0,RA1,RA2,8'h00,8'h00, 3'b000,3'b000,8'h00,1'b0,1'b1,17'h0,8'h00,1'b0,1'b0,3'd0,8'h00};
    // fairness: round-robin 0,1,2,0,1,2 with one-cycle read return
    vecs[1]  = '{1'b0,1'b0,1'b0,3'b111,3'b000,RA0,RA1,RA2,8'h00,8'h00, 3'b001,3'b000,8'h00,1'b1,1'b1,17'h100,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[2]  = '{1'b0,1'b0,1'b0,3'b111,3'b000,RA0,RA1,RA2,8'h00,8'h00, 3'b010,3'b001,8'h5B,1'b1,1'b1,17'h200,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[3]  = '{1'b0,1'b0,1'b0,3'b111,3'b000,RA0,RA1,RA2,8'h00,8'h00, 3'b100,3'b010,8'h58,1'b1,1'b1,17'h300,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[4]  = '{1'b0,1'b0,1'b0,3'b111,3'b000,RA0,RA1,RA2,8'h00,8'h00, 3'b001,3'b100,8'h59,1'b1,1'b1,17'h100,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[5]  = '{1'b0,1'b0,1'b0,3'b111,3'b000,RA0,RA1,RA2,8'h00,8'h00, 3'b010,3'b001,8'h5B,1'b1,1'b1,17'h200,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[6]  = '{1'b0,1'b0,1'b0,3'b111,3'b000,RA0,RA1,RA2,8'h00,8'h00, 3'b100,3'b010,8'h58,1'b1,1'b1,17'h300,8'h00,1'b0,1'b0,3'd0,8'h00};
    // region decode: I/O read at 0x30004
    vecs[7]  = '{1'b0,1'b0,1'b0,3'b010,3'b000,Z,32'h0003_0004,Z,8'h00,8'h00, 3'b010,3'b100,8'h59,1'b0,1'b1,17'h0,8'h00,1'b1,1'b0,3'd4,8'h00};
    vecs[8]  = '{1'b0,1'b0,1'b0,3'b000,3'b000,Z,Z,Z,8'h00,8'h00, 3'b000,3'b010,8'hC4,1'b0,1'b1,17'h0,8'h00,1'b0,1'b0,3'd0,8'h00};
    // backpressure: I/O write held while full, then released
    vecs[9]  = '{1'b0,1'b0,1'b1,3'b011,3'b001,32'h0003_0000,32'h0000_0010,Z,8'hAA,8'h00, 3'b010,3'b000,8'h00,1'b1,1'b1,17'h10,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[10] = '{1'b0,1'b0,1'b0,3'b001,3'b001,32'h0003_0000,Z,Z,8'hAA,8'h00, 3'b001,3'b010,8'h4A,1'b0,1'b1,17'h0,8'h00,1'b1,1'b1,3'd0,8'hAA};
    // I/O reads are not blocked by io_full
    vecs[11] = '{1'b0,1'b0,1'b1,3'b100,3'b000,Z,Z,32'h0003_0007,8'h00,8'h00, 3'b100,3'b000,8'h00,1'b0,1'b1,17'h0,8'h00,1'b1,1'b0,3'd7,8'h00};
    vecs[12] = '{1'b0,1'b0,1'b1,3'b000,3'b000,Z,Z,Z,8'h00,8'h00, 3'b000,3'b100,8'hC7,1'b0,1'b1,17'h0,8'h00,1'b0,1'b0,3'd0,8'h00};
    // debug lock: only master 2, then zero grants for 5 cycles
    vecs[13] = '{1'b0,1'b1,1'b0,3'b101,3'b000,RA0,Z,RA2,8'h00,8'h00, 3'b100,3'b000,8'h00,1'b1,1'b1,17'h300,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[14] = '{1'b0,1'b1,1'b0,3'b001,3'b000,RA0,Z,Z,8'h00,8'h00, 3'b000,3'b100,8'h59,1'b0,1'b1,17'h0,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[15] = '{1'b0,1'b1,1'b0,3'b001,3'b000,RA0,Z,Z,8'h00,8'h00, 3'b000,3'b000,8'h00,1'b0,1'b1,17'h0,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[16] = vecs[15];
    vecs[17] = vecs[15];
    vecs[18] = vecs[15];
    // pending read completes across a debug lock
    vecs[19] = '{1'b0,1'b0,1'b0,3'b001,3'b000,RA0,Z,Z,8'h00,8'h00, 3'b001,3'b000,8'h00,1'b1,1'b1,17'h100,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[20] = '{1'b0,1'b1,1'b0,3'b001,3'b000,RA0,Z,Z,8'h00,8'h00, 3'b000,3'b001,8'h5B,1'b0,1'b1,17'h0,8'h00,1'b0,1'b0,3'd0,8'h00};
    // reset mid-operation drops the pending return and restarts the pointer
    vecs[21] = '{1'b0,1'b0,1'b0,3'b111,3'b000,RA0,RA1,RA2,8'h00,8'h00, 3'b010,3'b000,8'h00,1'b1,1'b1,17'h200,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[22] = '{1'b1,1'b0,1'b0,3'b111,3'b000,RA0,RA1,RA2,8'h00,8'h00, 3'b000,3'b000,8'h00,1'b0,1'b1,17'h0,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[23] = '{1'b0,1'b0,1'b0,3'b111,3'b000,RA0,RA1,RA2,8'h00,8'h00, 3'b001,3'b000,8'h00,1'b1,1'b1,17'h100,8'h00,1'b0,1'b0,3'd0,8'h00};
    vecs[24] = '{1'b0,1'b0,1'b0,3'b000,3'b000,Z,Z,Z,8'h00,8'h00, 3'b000,3'b001,8'h5B,1'b0,1'b1,17'h0,8'h00,1'b0,1'b0,3'd0,8'h00};
    // RAM write: no read return afterwards
    vecs[25] = '{1'b0,1'b0,1'b0,3'b010,3'b010,Z,32'h0000_1234,Z,8'h00,8'h77, 3'b010,3'b000,8'h00,1'b1,1'b0,17'h1234,8'h77,1'b0,1'b0,3'd0,8'h00};
    vecs[26] = '{1'b0,1'b0,1'b0,3'b000,3'b000,Z,Z,Z,8'h00,8'h00, 3'b000,3'b000,8'h00,1'b0,1'b1,17'h0,8'h00,1'b0,1'b0,3'd0,8'h00};

    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Multi-cycle reset with everyone requesting, then recovery from pointer 0.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      rst_in = 1'b1;
      m_req  = 3'b111;
      m_wr   = 3'b000;
      m_a    = {RA2, RA1, RA0};
      m_dout = '0;
      #1;
      checkOutput($sformatf("rst%0d m_gnt", c), 32'(m_gnt), 32'h0);
      checkOutput($sformatf("rst%0d ram_en", c), 32'(ram_en), 32'h0);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    checkOutput("post-reset m_gnt", 32'(m_gnt), 32'h1);
    @(negedge clk_in);
    m_req = 3'b000;
    #1;
    waited = 0;
    while (m_rvalid == 3'b000 && waited < 4) begin
      @(negedge clk_in);
      #1;
      waited++;
    end
    checkOutput("post-reset rvalid", 32'(m_rvalid), 32'h1);
    checkOutput("post-reset m_din", 32'(m_din), 32'h5B);
    checkOutput("post-reset latency", 32'(waited), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
